// File: rtl/f1_lights_seq.sv
// ---------------------------------------------------------------------------
// f1_lights_seq
//
// Start-light sequencer for the F1 reaction-timer datapath. After a trigger
// the lamps light one per enable tick (LSB first). Once all NUM_LIGHTS are
// lit they are held for MIN_DELAY + LFSR[DELAY_W-1:0] (+1) enable ticks.
// Then everything goes dark and lights_out pulses for one clock. That pulse
// is the reaction-timer start strobe.
//
// The hold delay comes from an internal 16-bit Galois LFSR (right shift,
// taps 16'hB400). It free-runs every clock, so the delay depends on how many
// clocks have passed since reset when the hold phase is entered.
//
// Optional feature, macro F1_FALSE_START_EN:
//   Adds input jump, output fault and a FAULT state. A jump during FILL or
//   HOLD aborts the sequence without a lights_out pulse. The lamps then
//   flash on each enable tick until an enable tick arrives with trigger low.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   synchronous active-low reset
//   en         in   step tick; gates FILL/HOLD (and FAULT) progression only
//   trigger    in   start request, sampled every clock while idle
//   jump       in   false-start input (F1_FALSE_START_EN only)
//   data_out   out  lamp vector, bit i = lamp i
//   cmd_seq    out  high while filling
//   cmd_delay  out  high while holding
//   lights_out out  one-clock strobe when the lamps go dark
//   busy       out  high whenever a sequence is in progress
//   fault      out  high in FAULT (F1_FALSE_START_EN only)
//
// All outputs are decoded from registered state only. No input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module f1_lights_seq #(
  parameter int unsigned NUM_LIGHTS = 8,
  parameter int unsigned DELAY_W    = 7,
  parameter int unsigned MIN_DELAY  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  trigger,
`ifdef F1_FALSE_START_EN
  input  logic                  jump,
  output logic                  fault,
`endif
  output logic [NUM_LIGHTS-1:0] data_out,
  output logic                  cmd_seq,
  output logic                  cmd_delay,
  output logic                  lights_out,
  output logic                  busy
);

  localparam int unsigned   LW        = $clog2(NUM_LIGHTS + 1);
  // One extra bit, so MIN_DELAY + random field can never wrap.
  localparam int unsigned   CW        = DELAY_W + 1;
  localparam logic [LW-1:0] LIT_FULL  = LW'(NUM_LIGHTS);
  localparam logic [CW-1:0] MIN_D     = CW'(MIN_DELAY);
  localparam logic [15:0]   LFSR_TAPS = 16'hB400;

`ifdef F1_FALSE_START_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HOLD, S_OUT, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD, S_OUT} state_t;
`endif

  state_t        r_state;
  logic [LW-1:0] r_lit_cnt;
  logic [CW-1:0] r_delay_cnt;
  logic [15:0]   r_lfsr;

  state_t        w_state_nxt;
  logic [LW-1:0] w_lit_nxt;
  logic [CW-1:0] w_delay_nxt;
  logic [15:0]   w_lfsr_nxt;
  logic [CW-1:0] w_delay_load;

`ifdef F1_FALSE_START_EN
  // Flash phase while in FAULT. Set to 1 on entry so the lamps start lit.
  logic          r_blink;
  logic          w_blink_nxt;
`endif

  // Galois right shift. The bit shifted out folds back through the taps.
  assign w_lfsr_nxt   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign w_delay_load = MIN_D + {1'b0, r_lfsr[DELAY_W-1:0]};

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lit_cnt   <= '0;
      r_delay_cnt <= '0;
      r_lfsr      <= LFSR_SEED;
`ifdef F1_FALSE_START_EN
      r_blink     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_lit_cnt   <= w_lit_nxt;
      r_delay_cnt <= w_delay_nxt;
      r_lfsr      <= w_lfsr_nxt;
`ifdef F1_FALSE_START_EN
      r_blink     <= w_blink_nxt;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_lit_nxt   = r_lit_cnt;
    w_delay_nxt = r_delay_cnt;
`ifdef F1_FALSE_START_EN
    w_blink_nxt = r_blink;
`endif
    case (r_state)
      S_IDLE: begin
        // The trigger is level sampled and does not wait for en.
        if (trigger) begin
          w_state_nxt = S_FILL;
          w_lit_nxt   = LW'(1);
        end
      end
      S_FILL: begin
        if (en) begin
          if (r_lit_cnt == LIT_FULL) begin
            w_state_nxt = S_HOLD;
            w_delay_nxt = w_delay_load;
          end else begin
            w_lit_nxt = r_lit_cnt + LW'(1);
          end
        end
      end
      S_HOLD: begin
        // The counter reaching zero still costs one tick, so a hold of d
        // lasts d+1 enable ticks.
        if (en) begin
          if (r_delay_cnt == '0) w_state_nxt = S_OUT;
          else                   w_delay_nxt = r_delay_cnt - CW'(1);
        end
      end
      S_OUT: begin
        w_state_nxt = S_IDLE;
        w_lit_nxt   = '0;
      end
`ifdef F1_FALSE_START_EN
      S_FAULT: begin
        if (en) begin
          if (!trigger) w_state_nxt = S_IDLE;
          else          w_blink_nxt = ~r_blink;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef F1_FALSE_START_EN
    // A false start overrides whatever FILL/HOLD would have done this edge,
    // including a HOLD->OUT step. The aborted sequence never strobes.
    if (jump && (r_state == S_FILL || r_state == S_HOLD)) begin
      w_state_nxt = S_FAULT;
      w_blink_nxt = 1'b1;
      w_lit_nxt   = '0;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Output decode (registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    data_out   = '0;
    cmd_seq    = 1'b0;
    cmd_delay  = 1'b0;
    lights_out = 1'b0;
    busy       = 1'b0;
`ifdef F1_FALSE_START_EN
    fault      = 1'b0;
`endif
    case (r_state)
      S_FILL: begin
        cmd_seq = 1'b1;
        busy    = 1'b1;
        // Thermometer code: the lowest r_lit_cnt lamps are lit.
        for (int i = 0; i < int'(NUM_LIGHTS); i++)
          data_out[i] = (LW'(i) < r_lit_cnt);
      end
      S_HOLD: begin
        cmd_delay = 1'b1;
        busy      = 1'b1;
        data_out  = '1;
      end
      S_OUT: begin
        lights_out = 1'b1;
        busy       = 1'b1;
      end
`ifdef F1_FALSE_START_EN
      S_FAULT: begin
        fault    = 1'b1;
        busy     = 1'b1;
        data_out = r_blink ? '1 : '0;
      end
`endif
      default: begin
        data_out = '0;
      end
    endcase
  end

endmodule
